// File: rtl/serial_tx_arbiter_if.sv
// serial_tx_arbiter_if: requester handshake plus send_serial drive/status bundle.
// The slave modport is the arbiter's view; master is the producers/UART side.
interface serial_tx_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = 8
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_last;
    logic [NUM_REQ-1:0]        req_ready;
    logic [DATA_W-1:0]         tx_data;
    logic                      tx_we;
    logic                      tx_busy;
    logic [NUM_REQ-1:0]        grant;
    logic                      tx_err;

    modport master (
        output req_valid, req_data, req_last, tx_busy,
        input  req_ready, tx_data, tx_we, grant, tx_err
    );

    modport slave (
        input  req_valid, req_data, req_last, tx_busy,
        output req_ready, tx_data, tx_we, grant, tx_err
    );
endinterface

// File: rtl/serial_tx_arbiter.sv
// serial_tx_arbiter: round-robin sharing of one send_serial transmitter among NUM_REQ
// byte requesters; a packet keeps the grant until its last byte has left the line.
module serial_tx_arbiter #(
    parameter int NUM_REQ      = 2,
    parameter int DATA_W       = 8,
    parameter int BUSY_TIMEOUT = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    serial_tx_arbiter_if.slave bus
);
    localparam int PW = $clog2(NUM_REQ);
    localparam int TW = $clog2(BUSY_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_ISSUE, S_WAIT_BUSY, S_WAIT_DONE
    } state_t;

    state_t              r_state, w_next;
    logic [PW-1:0]       r_ptr, r_gidx, w_pick;
    logic [NUM_REQ-1:0]  r_grant;
    logic [DATA_W-1:0]   r_tx_data;
    logic                r_last;
    logic [TW-1:0]       r_timer;
    logic                w_done, w_err, w_own_valid;

    assign w_own_valid   = bus.req_valid[r_gidx];
    assign bus.tx_we     = r_state == S_ISSUE;
    assign bus.tx_err    = w_err;
    assign bus.req_ready = (r_state == S_LOAD) ? r_grant : '0;
    assign bus.grant     = r_grant;
    assign bus.tx_data   = r_tx_data;

    // Descending scan so the requester closest to r_ptr is the last (winning) write.
    always_comb begin
        w_pick = r_ptr;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (bus.req_valid[(int'(r_ptr) + i) % NUM_REQ])
                w_pick = PW'((int'(r_ptr) + i) % NUM_REQ);
        end
    end

    always_comb begin
        w_next = r_state;
        w_done = 1'b0;
        w_err  = 1'b0;
        case (r_state)
            S_IDLE:      if (|bus.req_valid && !bus.tx_busy) w_next = S_LOAD;
            S_LOAD:      if (w_own_valid) w_next = S_ISSUE;
            S_ISSUE:     w_next = S_WAIT_BUSY;
            S_WAIT_BUSY: begin
                if (bus.tx_busy) w_next = S_WAIT_DONE;
                else if (r_timer == TW'(BUSY_TIMEOUT - 1)) begin
                    w_err  = 1'b1;
                    w_done = 1'b1;
                end
            end
            S_WAIT_DONE: w_done = !bus.tx_busy;
            default:     w_next = S_IDLE;
        endcase
        // A timed-out byte leaves exactly like a completed one.
        if (w_done) w_next = r_last ? S_IDLE : S_LOAD;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= S_IDLE;
            r_ptr     <= '0;
            r_gidx    <= '0;
            r_grant   <= '0;
            r_tx_data <= '0;
            r_last    <= 1'b0;
            r_timer   <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && w_next == S_LOAD) begin
                r_gidx  <= w_pick;
                r_grant <= NUM_REQ'(1) << w_pick;
            end
            if (r_state == S_LOAD && w_own_valid) begin
                r_tx_data <= bus.req_data[int'(r_gidx)*DATA_W +: DATA_W];
                r_last    <= bus.req_last[r_gidx];
            end
            if (r_state == S_ISSUE) r_timer <= '0;
            else if (r_state == S_WAIT_BUSY && !bus.tx_busy) r_timer <= r_timer + 1'b1;
            if (w_done && r_last) begin
                r_grant <= '0;
                r_ptr   <= (r_gidx == PW'(NUM_REQ - 1)) ? '0 : r_gidx + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_serial_tx_arbiter.sv
// tb_serial_tx_arbiter: directed scenarios against queue-fed requesters and a
// send_serial busy stub that can also be forced high or low.
module tb_serial_tx_arbiter;
    localparam int N = 2, DW = 8, BT = 16, BL = 6;

    logic clk = 1'b0, rst_n = 1'b0;
    always #5 clk = ~clk;

    serial_tx_arbiter_if #(.NUM_REQ(N), .DATA_W(DW)) bus();
    serial_tx_arbiter #(.NUM_REQ(N), .DATA_W(DW), .BUSY_TIMEOUT(BT)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .bus(bus)
    );

    int n_tests = 0, n_fail = 0;
    logic [8:0] pq [N][$];
    bit pend [N];
    logic [7:0] log_d [$];
    logic [1:0] log_g [$];
    int cyc = 0, we_cyc = 0, err_cyc = 0, vset_cyc = 0, err_cnt = 0, rdy_cnt = 0, busy_we = 0;
    logic m_auto = 1'b1, m_force = 1'b0, m_busy = 1'b0;
    int m_cnt = 0;

    assign bus.tx_busy = m_auto ? m_busy : m_force;

    // Busy rises on the edge that sees tx_we and holds for BL cycles.
    always @(posedge clk) begin
        if (m_auto && bus.tx_we) begin
            m_busy <= 1'b1;
            m_cnt  <= BL;
        end else if (m_cnt > 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) m_busy <= 1'b0;
        end
    end

    always @(negedge clk) begin
        logic [N-1:0] v, l;
        logic [N*DW-1:0] d;
        cyc++;
        for (int k = 0; k < N; k++) begin
            if (pend[k]) begin
                if (pq[k].size() > 0) void'(pq[k].pop_front());
                pend[k] = 1'b0;
            end
        end
        if (bus.tx_we) begin
            log_d.push_back(bus.tx_data);
            log_g.push_back(bus.grant);
            we_cyc = cyc;
            if (bus.tx_busy) busy_we++;
        end
        if (bus.tx_err) begin
            err_cnt++;
            err_cyc = cyc;
        end
        if (|bus.req_ready) rdy_cnt++;
        for (int k = 0; k < N; k++) if (bus.req_valid[k] && bus.req_ready[k]) pend[k] = 1'b1;
        v = '0; l = '0; d = '0;
        for (int k = 0; k < N; k++) begin
            if (pq[k].size() > 0) begin
                v[k] = 1'b1;
                l[k] = pq[k][0][8];
                d[k*DW +: DW] = pq[k][0][7:0];
            end
        end
        if (v != '0 && bus.req_valid == '0) vset_cyc = cyc;
        bus.req_valid = v;
        bus.req_last  = l;
        bus.req_data  = d;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic clear_logs;
        log_d.delete();
        log_g.delete();
        err_cnt = 0;
        rdy_cnt = 0;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        for (int k = 0; k < N; k++) begin
            pq[k].delete();
            pend[k] = 1'b0;
        end
        tick(2);
        rst_n = 1'b1;
        tick(1);
        clear_logs();
    endtask

    task automatic wait_idle(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            tick(1);
            if (pq[0].size() == 0 && pq[1].size() == 0 && !pend[0] && !pend[1] &&
                bus.grant == '0 && !bus.tx_busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        tick(2);
        n_tests++; if (bus.tx_we !== 1'b0) begin n_fail++; $display("FAIL reset_tx_we: got %b want 0", bus.tx_we); end
        n_tests++; if (bus.tx_err !== 1'b0) begin n_fail++; $display("FAIL reset_tx_err: got %b want 0", bus.tx_err); end
        n_tests++; if (bus.grant !== 2'b00) begin n_fail++; $display("FAIL reset_grant: got %b want 00", bus.grant); end
        n_tests++; if (bus.req_ready !== 2'b00) begin n_fail++; $display("FAIL reset_ready: got %b want 00", bus.req_ready); end
        n_tests++; if (bus.tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data: got %h want 00", bus.tx_data); end
        rst_n = 1'b1;
        tick(1);
    endtask

    task automatic test_single;
        bit ok;
        clear_logs();
        pq[0].push_back({1'b1, 8'h53});
        wait_idle(60, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL single_idle: got timeout want idle"); end
        n_tests++; if (log_d.size() !== 1) begin n_fail++; $display("FAIL single_count: got %0d want 1", log_d.size()); end
        n_tests++; if (log_d[0] !== 8'h53) begin n_fail++; $display("FAIL single_data: got %h want 53", log_d[0]); end
        n_tests++; if (log_g[0] !== 2'b01) begin n_fail++; $display("FAIL single_grant: got %b want 01", log_g[0]); end
        n_tests++; if (we_cyc - vset_cyc !== 2) begin n_fail++; $display("FAIL single_latency: got %0d want 2", we_cyc - vset_cyc); end
        n_tests++; if (rdy_cnt !== 1) begin n_fail++; $display("FAIL single_ready_pulses: got %0d want 1", rdy_cnt); end
    endtask

    task automatic test_round_robin;
        bit ok1, ok2;
        logic [7:0] exp_d [4] = '{8'h41, 8'h42, 8'h41, 8'h42};
        logic [1:0] exp_g [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
        do_reset();
        pq[0].push_back({1'b1, 8'h41});
        pq[1].push_back({1'b1, 8'h42});
        wait_idle(100, ok1);
        pq[0].push_back({1'b1, 8'h41});
        pq[1].push_back({1'b1, 8'h42});
        wait_idle(100, ok2);
        n_tests++; if (!(ok1 && ok2)) begin n_fail++; $display("FAIL rr_idle: got timeout want idle"); end
        n_tests++; if (log_d.size() !== 4) begin n_fail++; $display("FAIL rr_count: got %0d want 4", log_d.size()); end
        for (int i = 0; i < 4; i++) begin
            n_tests++; if (log_d[i] !== exp_d[i]) begin n_fail++; $display("FAIL rr_data[%0d]: got %h want %h", i, log_d[i], exp_d[i]); end
            n_tests++; if (log_g[i] !== exp_g[i]) begin n_fail++; $display("FAIL rr_grant[%0d]: got %b want %b", i, log_g[i], exp_g[i]); end
        end
    endtask

    task automatic test_packet;
        bit ok;
        logic [7:0] exp_d [4] = '{8'h10, 8'h11, 8'h12, 8'h20};
        logic [1:0] exp_g [4] = '{2'b10, 2'b10, 2'b10, 2'b01};
        clear_logs();
        pq[1].push_back({1'b0, 8'h10});
        pq[1].push_back({1'b0, 8'h11});
        pq[1].push_back({1'b1, 8'h12});
        tick(2);
        n_tests++; if (bus.grant !== 2'b10) begin n_fail++; $display("FAIL pkt_first_grant: got %b want 10", bus.grant); end
        pq[0].push_back({1'b1, 8'h20});
        wait_idle(150, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL pkt_idle: got timeout want idle"); end
        n_tests++; if (log_d.size() !== 4) begin n_fail++; $display("FAIL pkt_count: got %0d want 4", log_d.size()); end
        for (int i = 0; i < 4; i++) begin
            n_tests++; if (log_d[i] !== exp_d[i]) begin n_fail++; $display("FAIL pkt_data[%0d]: got %h want %h", i, log_d[i], exp_d[i]); end
            n_tests++; if (log_g[i] !== exp_g[i]) begin n_fail++; $display("FAIL pkt_grant[%0d]: got %b want %b", i, log_g[i], exp_g[i]); end
        end
    endtask

    task automatic test_timeout;
        bit ok;
        clear_logs();
        m_auto  = 1'b0;
        m_force = 1'b0;
        pq[0].push_back({1'b1, 8'h77});
        wait_idle(60, ok);
        m_auto = 1'b1;
        n_tests++; if (!ok) begin n_fail++; $display("FAIL to_idle: got timeout want idle"); end
        n_tests++; if (err_cnt !== 1) begin n_fail++; $display("FAIL to_err_count: got %0d want 1", err_cnt); end
        n_tests++; if (err_cyc - we_cyc !== BT) begin n_fail++; $display("FAIL to_err_delay: got %0d want %0d", err_cyc - we_cyc, BT); end
        n_tests++; if (log_d[0] !== 8'h77) begin n_fail++; $display("FAIL to_data: got %h want 77", log_d[0]); end
    endtask

    task automatic test_reset_mid;
        bit ok, seen;
        logic [7:0] exp_d [2] = '{8'h61, 8'h62};
        clear_logs();
        seen = 1'b0;
        pq[0].push_back({1'b1, 8'h55});
        for (int i = 0; i < 20 && !seen; i++) begin
            tick(1);
            seen = log_d.size() == 1;
        end
        n_tests++; if (!seen) begin n_fail++; $display("FAIL mid_we_seen: got none want 1 byte"); end
        tick(2);
        n_tests++; if (bus.grant !== 2'b01) begin n_fail++; $display("FAIL mid_grant_before: got %b want 01", bus.grant); end
        #2 rst_n = 1'b0;
        #1;
        n_tests++; if (bus.grant !== 2'b00) begin n_fail++; $display("FAIL mid_grant_async: got %b want 00", bus.grant); end
        n_tests++; if (bus.tx_we !== 1'b0 || bus.req_ready !== 2'b00) begin n_fail++; $display("FAIL mid_we_ready_async: got %b/%b want 0/00", bus.tx_we, bus.req_ready); end
        n_tests++; if (bus.tx_data !== 8'h00) begin n_fail++; $display("FAIL mid_data_async: got %h want 00", bus.tx_data); end
        tick(2);
        rst_n = 1'b1;
        wait_idle(30, ok);
        clear_logs();
        pq[0].push_back({1'b1, 8'h61});
        pq[1].push_back({1'b1, 8'h62});
        wait_idle(100, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL mid_idle: got timeout want idle"); end
        for (int i = 0; i < 2; i++) begin
            n_tests++; if (log_d[i] !== exp_d[i]) begin n_fail++; $display("FAIL mid_order[%0d]: got %h want %h", i, log_d[i], exp_d[i]); end
        end
    endtask

    task automatic test_busy_block;
        bit ok;
        clear_logs();
        m_auto  = 1'b0;
        m_force = 1'b1;
        pq[0].push_back({1'b1, 8'h66});
        tick(20);
        n_tests++; if (rdy_cnt !== 0) begin n_fail++; $display("FAIL busy_ready: got %0d want 0", rdy_cnt); end
        n_tests++; if (log_d.size() !== 0) begin n_fail++; $display("FAIL busy_we: got %0d want 0", log_d.size()); end
        n_tests++; if (bus.grant !== 2'b00) begin n_fail++; $display("FAIL busy_grant: got %b want 00", bus.grant); end
        m_force = 1'b0;
        m_auto  = 1'b1;
        wait_idle(60, ok);
        n_tests++; if (!ok || log_d.size() !== 1) begin n_fail++; $display("FAIL busy_release: got %0d bytes want 1", log_d.size()); end
        n_tests++; if (log_d[0] !== 8'h66) begin n_fail++; $display("FAIL busy_data: got %h want 66", log_d[0]); end
        n_tests++; if (busy_we !== 0) begin n_fail++; $display("FAIL we_while_busy: got %0d want 0", busy_we); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_packet();
        test_timeout();
        test_reset_mid();
        test_busy_block();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
